seg_mux_ctrl: RTL

Time-multiplexing controller that shares one hex-to-seven-segment decoder between the two digits of a dual common-anode display. It holds a two-digit history: a new digit shifts in on the right and the previous right digit moves left. It drives the decoder's 4-bit input and the two active-low anode enables, with a blanking gap at every digit switch to suppress ghosting. It sits between the keypad/digit source and the existing seven-segment decoder.

---
 rtl/seg_mux_ctrl_pkg.sv | 20 ++
 rtl/seg_mux_ctrl_if.sv | 20 ++
 rtl/seg_mux_ctrl_dwell_timer.sv | 28 ++
 rtl/seg_mux_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seg_mux_ctrl_pkg.sv
// Shared state encoding and anode patterns for the two-digit display multiplexer.
package seg_mux_pkg;

    typedef enum logic [1:0] {
        S_BLANK_LO,
        S_SHOW_HI,
        S_BLANK_HI,
        S_SHOW_LO
    } state_t;

    // Active-low anode enables: [1] = left/high digit, [0] = right/low digit.
    localparam logic [1:0] ANODE_OFF = 2'b11;
    localparam logic [1:0] ANODE_HI  = 2'b01;
    localparam logic [1:0] ANODE_LO  = 2'b10;

    function automatic logic is_show(input state_t s);
        return (s == S_SHOW_HI) || (s == S_SHOW_LO);
    endfunction

endpackage

// File: rtl/seg_mux_ctrl_if.sv
// Digit-source handshake plus the shared decoder / anode drive of the display multiplexer.
interface seg_mux_ctrl_if;
    logic       digit_valid;
    logic [3:0] digit_in;
    logic       digit_ready;
    logic       clear;
    logic [3:0] hex_out;
    logic [1:0] anode_n;
    logic       frame_tick;

    modport master (
        output digit_valid, digit_in, clear,
        input  digit_ready, hex_out, anode_n, frame_tick
    );

    modport slave (
        input  digit_valid, digit_in, clear,
        output digit_ready, hex_out, anode_n, frame_tick
    );
endinterface

// File: rtl/seg_mux_ctrl_dwell_timer.sv
// Dwell counter: counts 0..limit-1 and restarts itself at terminal count.
// Latency: tc is combinational from the count register; the count reloads on the tc edge.
// Backpressure: none, free-running.
module dwell_timer #(
    parameter int CNT_W = 15
) (
    input  logic             int_osc,
    input  logic             reset,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // The limit may change on the tc edge; the fresh count starts from zero either way.
    assign tc = (cnt == (limit - CNT_W'(1)));

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_mux_ctrl.sv
// Time-multiplexes one hex decoder across two common-anode digits with blanking gaps.
// Latency: display outputs registered; a new digit commits at the next BLANK entry.
// Backpressure: one pending slot; digit_ready low while it is full or clear is high.
module seg_mux_ctrl
    import seg_mux_pkg::*;
#(
    parameter int REFRESH_CNT = 24000,
    parameter int BLANK_CNT   = 240,
    parameter int CNT_W       = 15
) (
    input  logic int_osc,
    input  logic reset,
    seg_mux_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] limit;
    logic             tc;

    logic [3:0] dig_hi;
    logic [3:0] dig_lo;
    logic [3:0] pend;
    logic       pend_full;
    logic [3:0] dig_hi_nxt;
    logic [3:0] dig_lo_nxt;
    logic       xfer;
    logic       commit;

    logic [1:0] anode_nxt;
    logic [3:0] hex_nxt;
    logic       tick_nxt;
    logic [1:0] anode_q;
    logic [3:0] hex_q;
    logic       tick_q;

    assign limit = is_show(state) ? CNT_W'(REFRESH_CNT) : CNT_W'(BLANK_CNT);

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .int_osc (int_osc),
        .reset   (reset),
        .limit   (limit),
        .tc      (tc)
    );

    assign bus.digit_ready = ~pend_full & ~bus.clear;
    assign xfer            = bus.digit_valid & bus.digit_ready;
    // Commits only on the edge leaving a SHOW state, so digits never change mid-dwell.
    assign commit          = tc & is_show(state) & pend_full;

    always_comb begin
        dig_hi_nxt = dig_hi;
        dig_lo_nxt = dig_lo;
        if (bus.clear) begin
            dig_hi_nxt = 4'h0;
            dig_lo_nxt = 4'h0;
        end else if (commit) begin
            dig_hi_nxt = dig_lo;
            dig_lo_nxt = pend;
        end
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            dig_hi    <= 4'h0;
            dig_lo    <= 4'h0;
            pend      <= 4'h0;
            pend_full <= 1'b0;
        end else begin
            dig_hi <= dig_hi_nxt;
            dig_lo <= dig_lo_nxt;
            if (bus.clear || commit) begin
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend_full <= 1'b1;
            end
            if (xfer) begin
                pend <= bus.digit_in;
            end
        end
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state <= S_BLANK_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are decoded from the next state and next digits so the registered
    // values line up with the state they belong to.
    always_comb begin
        state_nxt = state;
        anode_nxt = ANODE_OFF;
        hex_nxt   = dig_hi_nxt;
        tick_nxt  = 1'b0;
        if (tc) begin
            unique case (state)
                S_BLANK_LO: begin
                    state_nxt = S_SHOW_HI;
                    tick_nxt  = 1'b1;
                end
                S_SHOW_HI:  state_nxt = S_BLANK_HI;
                S_BLANK_HI: state_nxt = S_SHOW_LO;
                S_SHOW_LO:  state_nxt = S_BLANK_LO;
                default:    state_nxt = S_BLANK_LO;
            endcase
        end
        unique case (state_nxt)
            S_SHOW_HI: begin
                anode_nxt = ANODE_HI;
                hex_nxt   = dig_hi_nxt;
            end
            S_SHOW_LO: begin
                anode_nxt = ANODE_LO;
                hex_nxt   = dig_lo_nxt;
            end
            S_BLANK_HI: begin
                anode_nxt = ANODE_OFF;
                hex_nxt   = dig_lo_nxt;
            end
            default: begin
                anode_nxt = ANODE_OFF;
                hex_nxt   = dig_hi_nxt;
            end
        endcase
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            anode_q <= ANODE_OFF;
            hex_q   <= 4'h0;
            tick_q  <= 1'b0;
        end else begin
            anode_q <= anode_nxt;
            hex_q   <= hex_nxt;
            tick_q  <= tick_nxt;
        end
    end

    assign bus.anode_n    = anode_q;
    assign bus.hex_out    = hex_q;
    assign bus.frame_tick = tick_q;

endmodule
